mem_wb_stage: RTL

Memory stage of the five-stage pipeline plus the MEM/WB pipeline register. Consumes the EX/MEM register outputs, performs the data-memory load or store, and registers the load data and ALU result for write-back. Also flags misaligned word accesses and keeps load/store counters for debug.

---
 rtl/mem_wb_stage_if.sv | 50 +++++
 rtl/mem_wb_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_if
// Purpose  : Bundles the EX/MEM inputs and the MEM/WB outputs of the memory
//            stage, so the stage and its driver share one connection.
// Ports    : none (interface); parameter CNT_W sets the debug counter width.
//   master : drives the EX/MEM fields and observes the MEM/WB fields
//            (upstream pipeline / testbench side)
//   slave  : mem_wb_stage side
// Revision : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if #(
  parameter int CNT_W = 16
);
  // EX/MEM register outputs, consumed by the memory stage
  logic [31:0]      aluresult;
  logic [4:0]       rd;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic [31:0]      mem_forwarded_rtdata;

  // Memory stage and MEM/WB register outputs
  logic [31:0]      mem_fwd_data;
  logic [31:0]      memdataout;
  logic [31:0]      aluresultout;
  logic [4:0]       rdout;
  logic             MemtoRegout;
  logic             RegWriteout;
  logic [31:0]      wbdata;
  logic             align_err;
  logic [CNT_W-1:0] load_count;
  logic [CNT_W-1:0] store_count;

  modport master (
    output aluresult, rd, MemRead, MemWrite, MemtoReg, RegWrite,
           mem_forwarded_rtdata,
    input  mem_fwd_data, memdataout, aluresultout, rdout, MemtoRegout,
           RegWriteout, wbdata, align_err, load_count, store_count
  );

  modport slave (
    input  aluresult, rd, MemRead, MemWrite, MemtoReg, RegWrite,
           mem_forwarded_rtdata,
    output mem_fwd_data, memdataout, aluresultout, rdout, MemtoRegout,
           RegWriteout, wbdata, align_err, load_count, store_count
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory stage of the five-stage pipeline plus the MEM/WB pipeline
//            register. Performs the data-memory load or store, registers the
//            load data and ALU result for write-back, flags misaligned word
//            accesses (sticky) and keeps saturating load/store counters.
// Ports    :
//   clk    in  1  pipeline clock, all state updates on the rising edge
//   reset  in  1  asynchronous, active-high reset
//   bus    mem_wb_stage_if.slave
//          in : aluresult, rd, MemRead, MemWrite, MemtoReg, RegWrite,
//               mem_forwarded_rtdata
//          out: mem_fwd_data, memdataout, aluresultout, rdout, MemtoRegout,
//               RegWriteout, wbdata, align_err, load_count, store_count
// Params   : DEPTH_LOG2 - memory holds 2^DEPTH_LOG2 32-bit words
//            CNT_W      - width of the load/store counters (must match bus)
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DEPTH_LOG2 = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_wb_stage_if.slave        bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // --------------------------------------------------------------------------
  // Data memory. Not touched by reset; starts out all zeros.
  // --------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

  // --------------------------------------------------------------------------
  // Address decode and access qualification
  // --------------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  access;
  logic                  misaligned;
  logic                  load_ok;
  logic                  store_ok;
  logic [31:0]           rd_word;

  // Upper address bits are dropped, so addresses alias modulo the memory size.
  assign word_idx   = bus.aluresult[DEPTH_LOG2+1:2];
  assign access     = bus.MemRead | bus.MemWrite;
  assign misaligned = access & (bus.aluresult[1:0] != 2'b00);
  assign load_ok    = bus.MemRead  & ~misaligned;
  assign store_ok   = bus.MemWrite & ~misaligned;

  // Asynchronous read: if a (nominally illegal) load and store hit together,
  // this still returns the word as it was before the edge's write.
  assign rd_word    = mem_q[word_idx];

  // --------------------------------------------------------------------------
  // MEM/WB register state
  // --------------------------------------------------------------------------
  logic [31:0]      memdata_q,    memdata_d;
  logic [31:0]      aluresult_q,  aluresult_d;
  logic [4:0]       rd_q,         rd_d;
  logic             memtoreg_q,   memtoreg_d;
  logic             regwrite_q,   regwrite_d;
  logic             align_err_q,  align_err_d;
  logic [CNT_W-1:0] load_cnt_q,   load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q,  store_cnt_d;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             en);
    logic [CNT_W-1:0] res;
    res = val;
    if (en && (val != {CNT_W{1'b1}})) begin
      res = val + CNT_W'(1);
    end
    return res;
  endfunction

  always_comb begin
    memdata_d   = 32'h0;
    aluresult_d = bus.aluresult;
    rd_d        = bus.rd;
    memtoreg_d  = bus.MemtoReg;
    // A faulting access must never reach the register file.
    regwrite_d  = bus.RegWrite & ~misaligned;
    align_err_d = align_err_q | misaligned;
    load_cnt_d  = sat_inc(load_cnt_q,  load_ok);
    store_cnt_d = sat_inc(store_cnt_q, store_ok);

    // Non-loads and misaligned loads both capture zero.
    if (load_ok) begin
      memdata_d = rd_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memdata_q   <= 32'h0;
      aluresult_q <= 32'h0;
      rd_q        <= 5'h0;
      memtoreg_q  <= 1'b0;
      regwrite_q  <= 1'b0;
      align_err_q <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      memdata_q   <= memdata_d;
      aluresult_q <= aluresult_d;
      rd_q        <= rd_d;
      memtoreg_q  <= memtoreg_d;
      regwrite_q  <= regwrite_d;
      align_err_q <= align_err_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Memory write port. Kept out of the reset block so the array is not
  // reset; writes are suppressed while reset is high instead.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (store_ok && !reset) begin
      mem_q[word_idx] <= bus.mem_forwarded_rtdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.mem_fwd_data = bus.aluresult;
  assign bus.memdataout   = memdata_q;
  assign bus.aluresultout = aluresult_q;
  assign bus.rdout        = rd_q;
  assign bus.MemtoRegout  = memtoreg_q;
  assign bus.RegWriteout  = regwrite_q;
  assign bus.wbdata       = memtoreg_q ? memdata_q : aluresult_q;
  assign bus.align_err    = align_err_q;
  assign bus.load_count   = load_cnt_q;
  assign bus.store_count  = store_cnt_q;

endmodule
`default_nettype wire
